// File: rtl/serial_word_tx_if.sv
// Handshake bundle for serial_word_tx: parallel word input plus the serial
// din/din_valid/ready link toward the FIR deserializer.
interface serial_word_tx_if #(
    parameter int DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] i_word;
    logic                  i_word_valid;
    logic                  o_word_ready;
    logic                  o_sdout;
    logic                  o_sdout_valid;
    logic                  i_sready;

    modport master (
        input  i_word, i_word_valid, i_sready,
        output o_word_ready, o_sdout, o_sdout_valid
    );

    modport slave (
        output i_word, i_word_valid, i_sready,
        input  o_word_ready, o_sdout, o_sdout_valid
    );
endinterface

// File: rtl/serial_word_tx.sv
// Bit-serial word transmitter: small word FIFO feeding an LSB-first shifter
// with a fixed idle gap after every frame.
module serial_word_tx #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_en,
    serial_word_tx_if.master            sif,
    output logic                        o_busy,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
    output logic [CNT_WIDTH-1:0]        o_words_sent
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
    logic [CNT_WIDTH-1:0]  sent_q, sent_d;
    logic                  word_ready, push, pop;

    // Ready ignores a same-cycle pop so it never depends on FSM decode.
    assign word_ready = !i_rst && i_en && (count_q != OCC_W'(FIFO_DEPTH));
    assign push       = sif.i_word_valid && word_ready;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        sent_d    = sent_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop       = 1'b1;
                    shreg_d   = mem_q[rd_ptr_q];
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (sif.i_sready) begin
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
                        state_d   = GAP;
                        gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
                        sent_d    = sent_q + CNT_WIDTH'(1);
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) state_d = IDLE;
                else                 gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = sif.i_word;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase
    end

    // i_en low freezes every register, so the serial outputs hold as well.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            sent_q    <= '0;
        end else if (i_en) begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            sent_q    <= sent_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_en) mem_q <= mem_d;
    end

    assign sif.o_word_ready  = word_ready;
    assign sif.o_sdout_valid = (state_q == SHIFT);
    assign sif.o_sdout       = (state_q == SHIFT) && shreg_q[0];
    assign o_busy            = (state_q != IDLE) || (count_q != '0);
    assign o_fifo_count      = count_q;
    assign o_words_sent      = sent_q;
endmodule
